// File: rtl/dma_tdsp_bus_arbiter.sv
// Round-robin arbiter for the shared system bus between the DMA engine and the TDSP core.
// Grants are decoded from the state register; a turnaround state separates owners.
module dma_tdsp_bus_arbiter #(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dma_breq,
   output logic             dma_grant,
   input  logic             tdsp_breq,
   output logic             tdsp_grant,
   output logic [CNT_W-1:0] dma_gcnt,
   output logic [CNT_W-1:0] tdsp_gcnt,
   output logic             bus_busy
);

   localparam int HOLD_W = $clog2(HOLD_MAX);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      G_DMA  = 2'd1,
      G_TDSP = 2'd2,
      REL    = 2'd3
   } state_t;

   state_t            state;
   state_t            next_state;
   logic              last_tdsp;
   logic [HOLD_W-1:0] hold_cnt;
   logic              enter_dma;
   logic              enter_tdsp;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // The requester that did not own the bus last wins a tie.
   always_comb begin
      next_state = state;
      case (state)
         IDLE, REL: begin
            if (dma_breq && tdsp_breq) begin
               next_state = last_tdsp ? G_DMA : G_TDSP;
            end else if (dma_breq) begin
               next_state = G_DMA;
            end else if (tdsp_breq) begin
               next_state = G_TDSP;
            end else begin
               next_state = IDLE;
            end
         end
         G_DMA: begin
            if (!dma_breq || (tdsp_breq && hold_cnt == HOLD_LAST)) begin
               next_state = REL;
            end
         end
         G_TDSP: begin
            if (!tdsp_breq || (dma_breq && hold_cnt == HOLD_LAST)) begin
               next_state = REL;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      dma_grant  = (state == G_DMA);
      tdsp_grant = (state == G_TDSP);
      bus_busy   = dma_grant | tdsp_grant;
   end

   assign enter_dma  = (next_state == G_DMA)  && (state != G_DMA);
   assign enter_tdsp = (next_state == G_TDSP) && (state != G_TDSP);

   // Hold counter saturates so an uncontended owner can keep the bus forever.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_cnt  <= '0;
         last_tdsp <= 1'b1;
         dma_gcnt  <= '0;
         tdsp_gcnt <= '0;
      end else begin
         if (enter_dma || enter_tdsp) begin
            hold_cnt  <= '0;
            last_tdsp <= enter_tdsp;
         end else if ((state == G_DMA || state == G_TDSP) && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
         if (enter_dma) begin
            dma_gcnt <= dma_gcnt + 1'b1;
         end
         if (enter_tdsp) begin
            tdsp_gcnt <= tdsp_gcnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/dma_tdsp_bus_arbiter.md
# dma_tdsp_bus_arbiter

Two-requester bus arbiter that answers the DMA and TDSP bus-request handshake (`*_breq` in, `*_grant` out). It grants the shared bus round-robin, holds a grant while the owner keeps requesting, and preempts a long holder when the other side is waiting. It keeps per-requester grant counters so the request-side bench can check fairness directly. It sits between the DMA engine, the TDSP core and the shared system bus.

## Interface
- `HOLD_MAX`, 16: maximum grant length in cycles while the other requester is waiting; must be ≥ 2.
- `CNT_W`, 8: width of each grant counter.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dma_breq`  in  1  DMA bus request, level, synchronous to `clk`.
- `dma_grant`  out  1  DMA bus grant, registered.
- `tdsp_breq`  in  1  TDSP bus request, level, synchronous to `clk`.
- `tdsp_grant`  out  1  TDSP bus grant, registered.
- `dma_gcnt`  out  CNT_W  number of DMA grants issued, modulo 2^CNT_W.
- `tdsp_gcnt`  out  CNT_W  number of TDSP grants issued, modulo 2^CNT_W.
- `bus_busy`  out  1  equals `dma_grant | tdsp_grant`.

## Operation
- FSM states:
  - IDLE: no grant.
  - G_DMA: `dma_grant`=1.
  - G_TDSP: `tdsp_grant`=1.
  - REL: one turnaround cycle, no grant.
- Grants are decoded from registered state. `dma_grant` and `tdsp_grant` are never 1 in the same cycle.
- `last` flag records the most recent owner.
  - Reset value is TDSP, so DMA wins the first simultaneous request.
  - Updated on every grant entry.
- Arbitration happens in IDLE and REL:
  - Only one breq high: grant that requester.
  - Both high: grant the requester that is not `last`.
  - Neither high: go to or stay in IDLE.
- G_x to REL transitions:
  - Owner breq sampled low: go to REL.
  - Preempt: go to REL when `hold_cnt == HOLD_MAX-1` and the other breq is high. At the next arbitration the other side wins, because `last` points to the current owner.
  - Otherwise stay in G_x.
- Hold counter, width clog2(HOLD_MAX):
  - Cleared on grant entry; increments each cycle in G_x; saturates at HOLD_MAX-1.
  - An uncontended owner may hold indefinitely.
- Grant counters:
  - `*_gcnt` increments by 1 on each entry into its G_x state, including re-entry after preemption.
  - Wraps from 2^CNT_W-1 to 0.
- Reset (asserted low, at any time, including mid-grant):
  - Both grants=0, `bus_busy`=0, both counters=0, state=IDLE, `hold_cnt`=0, `last`=TDSP.
  - All outputs go to these values asynchronously.
  - First arbitration happens on the first rising edge with `reset` high.

## Timing
- Grant latency: breq first sampled high at edge N in IDLE gives grant=1 immediately after edge N, so it is first visible to a requester sampling at edge N+1.
- Release: owner breq sampled low at edge M gives grant=0 after edge M and state REL.
  - The other requester, if sampled high at edge M+1, is granted after edge M+1.
  - This guarantees at least one dead cycle between owners.
- Back-to-back re-request by the same sole requester: it regains the bus after REL, one dead cycle.
- Contended grant length: at most HOLD_MAX cycles, measured from grant entry to the edge that clears the grant.
- Simultaneous breq rise in IDLE: resolved by `last` in the same edge; no extra latency.
- breq dropping and the other breq rising at the same edge: go to REL, then grant the other.
- Counter increment is visible in the same cycle the grant first reads 1.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with both breq high. Required: grants=0, `bus_busy`=0, `dma_gcnt`=`tdsp_gcnt`=0 throughout. Releasing `reset` gives `dma_grant` after the first edge.
- Single request: `dma_breq` high for 5 cycles, then low.
  - `dma_grant` is high 1 cycle after the request and stays high until 1 cycle after the drop.
  - `dma_gcnt`=1; `tdsp_grant` stays 0.
- Simultaneous request after reset: both breq high.
  - DMA is granted first.
  - When DMA drops, one dead cycle follows, then `tdsp_grant`=1.
  - Counters end at 1/1.
- Preemption, HOLD_MAX=16: `dma_breq` held high; `tdsp_breq` rises 3 cycles into the DMA grant.
  - `dma_grant` is high for exactly 16 cycles, then one dead cycle, then `tdsp_grant`.
  - `dma_gcnt` is 2 after DMA regains the bus once TDSP drops its request.
- Fairness soak: 200 request pairs with random 0–31-cycle request delays on each side; each requester drops its breq 1 cycle after its grant.
  - Required: `dma_gcnt`=`tdsp_gcnt`=200.
  - No cycle with both grants high.
  - No request waits more than HOLD_MAX+2 cycles.
- Reset mid-grant: assert `reset` low while `tdsp_grant`=1.
  - `tdsp_grant` drops without waiting for a clock edge, and counters read 0.
  - After release, with both breq high, DMA is granted first.
